// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Executes register read/write command frames taken from the Rx FIFO
//   and pushes one response byte per frame into the Tx FIFO.
//   Frames: 0x57 addr data (write, reply 0x4B), 0x52 addr (read, reply data).
//   Unknown command or out-of-range address replies 0x3F.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   rx_fifo_*          first-word fall-through Rx FIFO read side
//   tx_fifo_*          Tx FIFO write side
//   regs_flat          register file, reg i at [8i+7:8i]
//   busy               high whenever the FSM is not idle
//   err_count          saturating count of rejected frames
//
// Build option
//   UART_CMD_TIMEOUT_EN  abort a partial frame (reply 0x21) after
//                        TIMEOUT_CYCLES cycles without a byte.
module uart_cmd_responder #(
  parameter int NUM_REGS       = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_fifo_empty,
  input  logic [DATA_WIDTH-1:0]          rx_fifo_dout,
  output logic                           rx_fifo_rd_en,
  input  logic                           tx_fifo_full,
  output logic                           tx_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]          tx_fifo_din,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           busy,
  output logic [7:0]                     err_count
);

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = 8'h57;
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = 8'h52;
  localparam logic [DATA_WIDTH-1:0] RSP_ACK   = 8'h4B;
  localparam logic [DATA_WIDTH-1:0] RSP_ERR   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_EXEC,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic [7:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  pop;
  logic                  err_inc;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] rd_val;

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [DATA_WIDTH-1:0] RSP_TIMEOUT = 8'h21;
  localparam logic [31:0]           TO_LIMIT    = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
`endif

  // Address compare is one bit wider so NUM_REGS=256 works.
  always_comb begin
    addr_ok = ({1'b0, addr_q} < 9'(NUM_REGS));
    rd_val  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    regs_d     = regs_q;
    err_inc    = 1'b0;
    // Reset gating keeps rd_en low while rst is asserted.
    pop        = rst && !rx_fifo_empty &&
                 (state_q == S_IDLE || state_q == S_GET_ADDR || state_q == S_GET_DATA);
`ifdef UART_CMD_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (rx_fifo_dout == CMD_WRITE || rx_fifo_dout == CMD_READ) begin
            is_write_d = (rx_fifo_dout == CMD_WRITE);
            state_d    = S_GET_ADDR;
          end else begin
            resp_d  = RSP_ERR;
            err_inc = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_GET_ADDR: begin
        if (pop) begin
          addr_d  = rx_fifo_dout;
          state_d = is_write_q ? S_GET_DATA : S_EXEC;
        end
      end
      S_GET_DATA: begin
        if (pop) begin
          data_d  = rx_fifo_dout;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (!addr_ok) begin
          resp_d  = RSP_ERR;
          err_inc = 1'b1;
        end else if (is_write_q) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) regs_d[i] = data_q;
          end
          resp_d = RSP_ACK;
        end else begin
          resp_d = rd_val;
        end
      end
      S_RESP: begin
        if (!tx_fifo_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    // Counter runs only while waiting mid-frame; any pop restarts it.
    if ((state_q == S_GET_ADDR || state_q == S_GET_DATA) && !pop) begin
      if (to_cnt_q == TO_LIMIT) begin
        resp_d  = RSP_TIMEOUT;
        err_inc = 1'b1;
        state_d = S_RESP;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      err_q      <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      regs_q     <= regs_d;
`ifdef UART_CMD_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // resp_q only changes on entry to RESP, so it doubles as the held Tx byte.
  always_comb begin
    rx_fifo_rd_en = pop;
    tx_fifo_wr_en = (state_q == S_RESP) && !tx_fifo_full;
    tx_fifo_din   = resp_q;
    busy          = (state_q != S_IDLE);
    err_count     = err_q;
    regs_flat     = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: models the Rx/Tx FIFOs with queues
// and checks responses, latency, back-pressure, reset and err_count saturation.
module tb_uart_cmd_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_fifo_empty;
  logic [7:0]   rx_fifo_dout;
  logic         rx_fifo_rd_en;
  logic         tx_fifo_full;
  logic         tx_fifo_wr_en;
  logic [7:0]   tx_fifo_din;
  logic [127:0] regs_flat;
  logic         busy;
  logic [7:0]   err_count;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .NUM_REGS      (16),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_dout (rx_fifo_dout),
    .rx_fifo_rd_en(rx_fifo_rd_en),
    .tx_fifo_full (tx_fifo_full),
    .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_din  (tx_fifo_din),
    .regs_flat    (regs_flat),
    .busy         (busy),
    .err_count    (err_count)
  );

  logic [7:0]   rx_q [$];
  logic [7:0]   tx_q [$];
  int           tests = 0;
  int           fails = 0;
  int           edge_n = 0;
  int           pops = 0;
  int           pushes = 0;
  int           last_pop = 0;
  int           last_push = 0;
  int           p0, n0;
  logic [127:0] exp_flat;
  logic [7:0]   exp_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx();
    rx_fifo_empty = (rx_q.size() == 0);
    rx_fifo_dout  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    drive_rx();
  endtask

  // Sample handshakes mid-cycle, then apply the FIFO effects after the edge.
  task automatic tick();
    logic       p, w;
    logic [7:0] d;
    @(negedge clk);
    p = rx_fifo_rd_en;
    w = tx_fifo_wr_en;
    d = tx_fifo_din;
    @(posedge clk);
    #1;
    edge_n++;
    if (p) begin
      void'(rx_q.pop_front());
      pops++;
      last_pop = edge_n;
    end
    if (w) begin
      tx_q.push_back(d);
      pushes++;
      last_push = edge_n;
    end
    drive_rx();
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 128'(tx_q.size()), 128'(n));
  endtask

  task automatic wait_rx_empty(input int budget, input string tag);
    int k = 0;
    while (rx_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 128'(rx_q.size()), 128'd0);
  endtask

  initial begin
    rst           = 1'b0;
    rx_fifo_empty = 1'b0;
    rx_fifo_dout  = 8'h57;
    tx_fifo_full  = 1'b0;
    exp_flat      = '0;
    exp_err       = 8'h00;

    // Reset values, with a byte offered to prove rd_en stays low.
    #2;
    check("rst_rd_en", 128'(rx_fifo_rd_en), 128'd0);
    check("rst_wr_en", 128'(tx_fifo_wr_en), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err_count), 128'd0);
    check("rst_din", 128'(tx_fifo_din), 128'd0);
    check("rst_regs", regs_flat, 128'd0);
    rx_fifo_empty = 1'b1;
    rx_fifo_dout  = 8'h00;
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Write reg3, read it back, write reg2.
    push(8'h57); push(8'h03); push(8'hA5);
    push(8'h52); push(8'h03);
    push(8'h57); push(8'h02); push(8'h77);
    wait_tx(1, 20, "wr_wait");
    check("wr_resp", 128'(tx_q[0]), 128'h4B);
    check("wr_latency", 128'(last_push - last_pop), 128'd2);
    exp_flat[31:24] = 8'hA5;
    check("wr_reg3", regs_flat, exp_flat);
    wait_tx(2, 20, "rd_wait");
    check("rd_resp", 128'(tx_q[1]), 128'hA5);
    check("rd_latency", 128'(last_push - last_pop), 128'd2);
    wait_tx(3, 20, "wr2_wait");
    check("wr2_resp", 128'(tx_q[2]), 128'h4B);
    exp_flat[23:16] = 8'h77;
    check("wr2_regs", regs_flat, exp_flat);
    check("err_after_ok", 128'(err_count), 128'(exp_err));

    // Out-of-range address, then an unknown command.
    push(8'h57); push(8'h10); push(8'h11);
    wait_tx(4, 20, "badaddr_wait");
    check("badaddr_resp", 128'(tx_q[3]), 128'h3F);
    check("badaddr_regs", regs_flat, exp_flat);
    exp_err = 8'd1;
    check("badaddr_err", 128'(err_count), 128'(exp_err));
    push(8'h00);
    wait_tx(5, 20, "unk_wait");
    check("unk_resp", 128'(tx_q[4]), 128'h3F);
    check("unk_latency", 128'(last_push - last_pop), 128'd1);
    exp_err = 8'd2;
    check("unk_err", 128'(err_count), 128'(exp_err));

    // Back-pressure: Tx full through a read frame with another frame queued.
    tx_fifo_full = 1'b1;
    p0 = pops;
    n0 = pushes;
    push(8'h52); push(8'h03); push(8'h52); push(8'h00);
    repeat (10) tick();
    check("bp_pops", 128'(pops - p0), 128'd2);
    check("bp_pushes", 128'(pushes - n0), 128'd0);
    check("bp_busy", 128'(busy), 128'd1);
    check("bp_wr_en", 128'(tx_fifo_wr_en), 128'd0);
    check("bp_rd_en", 128'(rx_fifo_rd_en), 128'd0);
    tx_fifo_full = 1'b0;
    tick();
    check("bp_release_push", 128'(pushes - n0), 128'd1);
    check("bp_release_data", 128'(tx_q[5]), 128'hA5);
    repeat (3) tick();
    check("bp_single_pulse", 128'(pushes - n0), 128'd1);
    wait_tx(7, 20, "bp_next_wait");
    check("bp_next_data", 128'(tx_q[6]), 128'h00);
    check("bp_err", 128'(err_count), 128'(exp_err));

    // Trickled data byte: 50 idle cycles between addr and data.
    push(8'h57); push(8'h05);
    wait_rx_empty(10, "trickle_pop");
    repeat (50) tick();
`ifdef UART_CMD_TIMEOUT_EN
    check("to_count", 128'(tx_q.size()), 128'd8);
    check("to_resp", 128'(tx_q[7]), 128'h21);
    exp_err = 8'd3;
    check("to_err", 128'(err_count), 128'(exp_err));
    check("to_regs", regs_flat, exp_flat);
    check("to_idle", 128'(busy), 128'd0);
`else
    check("trickle_waiting", 128'(tx_q.size()), 128'd7);
    check("trickle_busy", 128'(busy), 128'd1);
    push(8'h3C);
    wait_tx(8, 20, "trickle_wait");
    check("trickle_resp", 128'(tx_q[7]), 128'h4B);
    exp_flat[47:40] = 8'h3C;
    check("trickle_regs", regs_flat, exp_flat);
    check("trickle_err", 128'(err_count), 128'(exp_err));
`endif

    // Reset in the middle of a write frame.
    tx_q.delete();
    push(8'h57); push(8'h02);
    wait_rx_empty(10, "midrst_pop");
    #2 rst = 1'b0;
    #1;
    exp_flat = '0;
    exp_err  = 8'd0;
    check("midrst_regs", regs_flat, exp_flat);
    check("midrst_err", 128'(err_count), 128'(exp_err));
    check("midrst_din", 128'(tx_fifo_din), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_wr_en", 128'(tx_fifo_wr_en), 128'd0);
    check("midrst_rd_en", 128'(rx_fifo_rd_en), 128'd0);
    repeat (2) tick();
    #3 rst = 1'b1;
    push(8'h52); push(8'h02);
    wait_tx(1, 20, "postrst_wait");
    check("postrst_resp", 128'(tx_q[0]), 128'h00);
    repeat (5) tick();
    check("postrst_no_stray", 128'(tx_q.size()), 128'd1);
    check("postrst_err", 128'(err_count), 128'd0);

    // err_count saturation over 260 unknown frames.
    tx_q.delete();
    for (int i = 0; i < 254; i++) push(8'h00);
    wait_tx(254, 1200, "sat_wait_254");
    check("sat_err_254", 128'(err_count), 128'hFE);
    for (int i = 0; i < 6; i++) push(8'h00);
    wait_tx(260, 100, "sat_wait_260");
    check("sat_err_260", 128'(err_count), 128'hFF);
    check("sat_last_resp", 128'(tx_q[259]), 128'h3F);
    push(8'h00);
    wait_tx(261, 20, "sat_wait_261");
    check("sat_err_hold", 128'(err_count), 128'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Command responder on the FIFO side of the UART top.
- Pops command frames from the Rx FIFO and executes reads and writes on an internal register file.
- Pushes one response byte per frame into the Tx FIFO.
- Gives the remote host register access over the UART link.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; legal 1..256.
- DATA_WIDTH, 8, byte width; fixed at 8.
- TIMEOUT_CYCLES, 1000000, inter-byte abort limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_fifo_empty  in  1  Rx FIFO empty flag
- rx_fifo_dout  in  8  Rx FIFO head byte; first-word fall-through, valid while rx_fifo_empty=0
- rx_fifo_rd_en  out  1  pop Rx FIFO head this cycle
- tx_fifo_full  in  1  Tx FIFO full flag
- tx_fifo_wr_en  out  1  push tx_fifo_din this cycle
- tx_fifo_din  out  8  response byte
- regs_flat  out  NUM_REGS*8  register file contents; reg i at bits [8i+7:8i]
- busy  out  1  high whenever state != IDLE
- err_count  out  8  count of rejected frames, saturating

Behaviour:
- Frame formats:
  - Write: 0x57, addr, data.
  - Read: 0x52, addr.
  - Any other first byte is an unknown command: the frame ends after that one byte.
- States: IDLE, GET_ADDR, GET_DATA, EXEC, RESP.
- Pop rule: in IDLE, GET_ADDR and GET_DATA, rx_fifo_rd_en = !rx_fifo_empty (combinational). The byte is latched on the same rising edge. Back-to-back pops on consecutive cycles are legal.
- Transitions:
  - IDLE: pop 0x57 or 0x52 -> GET_ADDR (command latched). Pop any other byte -> RESP with byte 0x3F.
  - GET_ADDR: pop -> addr latched. Write command -> GET_DATA. Read command -> EXEC.
  - GET_DATA: pop -> data latched -> EXEC.
  - EXEC, one cycle:
    - addr >= NUM_REGS: response 0x3F, no register change.
    - Write: reg[addr] <= data, response 0x4B.
    - Read: response reg[addr].
  - RESP: when !tx_fifo_full, assert tx_fifo_wr_en for exactly one cycle with tx_fifo_din = response, then -> IDLE. While full, hold RESP with wr_en=0 and no Rx pops.
- Latency:
  - Final frame byte popped at edge N. EXEC runs in cycle N+1; a register write is visible on regs_flat after edge N+1. tx_fifo_wr_en is high in cycle N+2 when Tx is not full.
  - Unknown command popped at edge N: tx_fifo_wr_en high in cycle N+1.
- err_count increments by 1 on each 0x3F response. It saturates at 0xFF.
- Read of a register in the same frame sequence right after a write to it returns the new value.
- tx_fifo_din holds its last value when wr_en=0.
- Reset (asynchronous, rst=0):
  - state=IDLE.
  - All registers, err_count and tx_fifo_din = 0.
  - rx_fifo_rd_en=0, tx_fifo_wr_en=0, busy=0.
  - Reset mid-frame discards the partial frame and sends no response.
- Reset release is synchronous to clk.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every pop and counts cycles spent in GET_ADDR or GET_DATA.
  - On reaching TIMEOUT_CYCLES-1 the partial frame is aborted -> RESP with byte 0x21, and err_count increments.
  - RESP and EXEC are never timed out.
- Undefined: no counter. The block waits indefinitely for the remaining frame bytes.

Test Plan:
- Write then read: push 0x57,0x03,0xA5 then 0x52,0x03 -> Tx receives 0x4B then 0xA5; regs_flat[31:24]=0xA5; err_count=0.
- Bad address, NUM_REGS=16: push 0x57,0x10,0x11 -> Tx 0x3F; regs_flat unchanged; err_count=1. Unknown command 0x00 -> Tx 0x3F after a 1-byte frame; err_count=2.
- Back-pressure: hold tx_fifo_full=1 through a read frame -> state held in RESP, no further Rx pops, wr_en=0. Release -> exactly one wr_en pulse carrying the data.
- Trickled bytes: Rx FIFO empty for 50 cycles between addr and data -> frame still completes and the write lands (macro undefined). With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=20 -> Tx 0x21, no write, err_count+1.
- Reset mid-frame: pull rst low after popping 0x57,0x02 -> outputs zero immediately. After release, push 0x52,0x02 -> Tx 0x00, no stray response.
- Saturation: 260 unknown-command frames -> err_count=0xFF and stays there.
